mem_req_unit: RTL and testbench
===============================

Name: mem_req_unit

Overview:
- Memory-side counterpart of the write-back load-alignment logic.
- Accepts one load/store per handshake from the EX stage.
- Formats byte strobes and write data for sb/sh/sw/swl/swr, and detects address-error exceptions.
- Drives the data-side SRAM-like bus (req/addr_ok/data_ok) with one transaction outstanding.
- Returns the raw read word plus its 2-bit byte offset (rdata_type) toward MEM/WB, where sub-word loads are aligned.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, bus data width (fixed 32; other values unsupported)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- es_req_valid  in  1  EX-stage memory op valid
- es_req_ready  out  1  unit can accept an op
- es_mem_op  in  12  one-hot: 0 lw, 1 sw, 2 lb, 3 lbu, 4 lh, 5 lhu, 6 lwl, 7 lwr, 8 sb, 9 sh, 10 swl, 11 swr
- es_addr  in  32  effective address
- es_rt_value  in  32  store source / lwl-lwr merge value
- flush  in  1  exception/eret flush; cancels current op
- data_req  out  1  bus request
- data_wr  out  1  1 = write
- data_size  out  2  0 byte, 1 half, 2 word
- data_addr  out  32  bus address
- data_wstrb  out  4  byte strobes (0 on reads)
- data_wdata  out  32  write data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  response/write-complete
- data_rdata  in  32  read data
- resp_valid  out  1  result valid toward MEM/WB
- resp_ready  in  1  downstream accepts result
- resp_rdata  out  32  registered read word (0 for stores)
- resp_rdata_type  out  2  es_addr[1:0] of the op
- resp_ex  out  1  address error (AdEL/AdES)
- resp_is_store  out  1  op was a store

Behaviour:
- States: IDLE, REQ, WAIT, RESP.
- Reset: state IDLE, cancel flag 0, and every output 0 except es_req_ready=1.
- es_req_ready = (state==IDLE) && !cancel.
- Accept = es_req_valid && es_req_ready && !flush. On accept, latch op, addr, rt, and formatted bus fields.
- Misalignment:
  - lw/sw: addr[1:0]!=0 is misaligned.
  - lh/lhu/sh: addr[0]!=0 is misaligned.
  - A misaligned op issues no bus request: IDLE->RESP with resp_ex=1.
  - Otherwise IDLE->REQ.
- REQ:
  - data_req=1 with stable fields from the cycle after accept.
  - data_addr_ok=1 -> WAIT the next cycle.
  - data_req must drop in the same cycle addr_ok is seen as registered (one request per op).
- WAIT:
  - data_data_ok=1 -> latch data_rdata (reads) and go to RESP next cycle.
  - Minimum latency accept->resp_valid: 3 cycles with addr_ok and data_ok each asserted in their first possible cycle.
- RESP: resp_valid=1 and outputs held stable until resp_ready=1, then IDLE. A new op may be accepted the cycle after.
- Bus formatting for loads:
  - lb/lbu: size 0, addr as-is.
  - lh/lhu: size 1, addr as-is.
  - lw: size 2.
  - lwl/lwr: size 2, addr {a[31:2],2'b00}.
  - wstrb=0 for all loads.
- Store formatting (off=addr[1:0], little-endian):
  - sb: size 0, wstrb=1<<off, wdata={4{rt[7:0]}}.
  - sh: size 1, wstrb off0 -> 0011, off2 -> 1100; wdata={2{rt[15:0]}}.
  - sw: size 2, wstrb 1111, wdata=rt.
  - swl (word-aligned addr, size 2):
    - off0: 0001, {24'b0,rt[31:24]}
    - off1: 0011, {16'b0,rt[31:16]}
    - off2: 0111, {8'b0,rt[31:8]}
    - off3: 1111, rt
  - swr (word-aligned addr, size 2):
    - off0: 1111, rt
    - off1: 1110, {rt[23:0],8'b0}
    - off2: 1100, {rt[15:0],16'b0}
    - off3: 1000, {rt[7:0],24'b0}
- Flush:
  - In IDLE: the same-cycle accept is suppressed.
  - In RESP: response dropped, -> IDLE.
  - In REQ or WAIT: set cancel. The bus transaction completes normally (req held to addr_ok, data_ok awaited) but goes to IDLE instead of RESP, with resp_valid never asserted.
  - cancel clears when the transaction ends. es_req_ready stays 0 while cancel=1.
- data_ok arriving in REQ or IDLE is a protocol violation and is ignored.
- Reset mid-transaction: immediate return to IDLE. The bus slave is reset by the same signal.

Decomposition:
- Shared package mem_pkg holds:
  - MEM_OP_* bit-index constants (12)
  - SIZE_BYTE/HALF/WORD
  - state encoding for IDLE/REQ/WAIT/RESP
- One combinational sub-module, store_formatter, is natural: (mem_op, addr, rt) -> (size, bus_addr, wstrb, wdata, misaligned).

Test Plan:
- sb addr 0x8000_0003, rt 0x1122_3344, addr_ok/data_ok immediate -> data_req 1 cycle after accept, wstrb 1000, wdata 0x4444_4444, size 0, resp_valid at cycle 3, resp_is_store=1.
- swr addr 0x1001, rt 0xAABB_CCDD -> data_addr 0x1000, wstrb 1110, wdata 0xBBCC_DD00; swl same addr -> wstrb 0011, wdata 0x0000_AABB.
- lh addr 0x2002, data_rdata 0x8765_4321 after data_ok delayed 5 cycles -> resp_rdata 0x8765_4321, rdata_type 2, resp_valid held 3 cycles with resp_ready=0 and data stable.
- lw addr 0x3001 -> no data_req ever, resp_valid with resp_ex=1 at cycle 1; sh addr 0x3001 -> resp_ex=1.
- lw issued, flush during WAIT, data_ok 2 cycles later -> resp_valid never asserts, es_req_ready 0 until cycle after data_ok, then 1.
- es_req_valid and flush same cycle in IDLE -> no accept, no data_req; back-to-back lw ops with resp_ready=1 -> second accept the cycle after first resp handshake.

Source files
------------

// File: rtl/mem_req_unit_pkg.sv
// Shared definitions for the data-side memory request unit: op bit indices,
// bus size codes and the request FSM state encoding.
package mem_pkg;

  localparam int MEM_OP_W   = 12;
  localparam int MEM_OP_LW  = 0;
  localparam int MEM_OP_SW  = 1;
  localparam int MEM_OP_LB  = 2;
  localparam int MEM_OP_LBU = 3;
  localparam int MEM_OP_LH  = 4;
  localparam int MEM_OP_LHU = 5;
  localparam int MEM_OP_LWL = 6;
  localparam int MEM_OP_LWR = 7;
  localparam int MEM_OP_SB  = 8;
  localparam int MEM_OP_SH  = 9;
  localparam int MEM_OP_SWL = 10;
  localparam int MEM_OP_SWR = 11;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  function automatic logic is_store_op(input logic [MEM_OP_W-1:0] op);
    return op[MEM_OP_SB] | op[MEM_OP_SH] | op[MEM_OP_SW] |
           op[MEM_OP_SWL] | op[MEM_OP_SWR];
  endfunction

endpackage

// File: rtl/mem_req_unit_store_formatter.sv
// Combinational bus formatting for one load/store: size, bus address,
// little-endian byte strobes, lane-replicated write data and alignment check.
module store_formatter
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [MEM_OP_W-1:0] mem_op,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [31:0]         rt,
  output logic [1:0]          size,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [3:0]          wstrb,
  output logic [31:0]         wdata,
  output logic                misaligned,
  output logic                is_store
);

  logic [1:0]        off;
  logic [ADDR_W-1:0] word_addr;

  assign off       = addr[1:0];
  assign word_addr = {addr[ADDR_W-1:2], 2'b00};

  // NOTE: every output gets a default first, so no path through the chain infers a latch.
  always_comb begin
    size       = SIZE_WORD;
    bus_addr   = addr;
    wstrb      = 4'b0000;
    wdata      = 32'h0;
    misaligned = 1'b0;
    is_store   = is_store_op(mem_op);
    if (mem_op[MEM_OP_LB] || mem_op[MEM_OP_LBU]) begin
      size = SIZE_BYTE;
    end else if (mem_op[MEM_OP_LH] || mem_op[MEM_OP_LHU]) begin
      size       = SIZE_HALF;
      misaligned = addr[0];
    end else if (mem_op[MEM_OP_LW]) begin
      misaligned = (off != 2'b00);
    end else if (mem_op[MEM_OP_LWL] || mem_op[MEM_OP_LWR]) begin
      bus_addr = word_addr;
    end else if (mem_op[MEM_OP_SB]) begin
      size  = SIZE_BYTE;
      wstrb = 4'b0001 << off;
      wdata = {4{rt[7:0]}};
    end else if (mem_op[MEM_OP_SH]) begin
      size       = SIZE_HALF;
      misaligned = addr[0];
      wstrb      = addr[1] ? 4'b1100 : 4'b0011;
      wdata      = {2{rt[15:0]}};
    end else if (mem_op[MEM_OP_SW]) begin
      misaligned = (off != 2'b00);
      wstrb      = 4'b1111;
      wdata      = rt;
    end else if (mem_op[MEM_OP_SWL]) begin
      // swl writes the high end of rt into the low bytes up to the offset
      bus_addr = word_addr;
      case (off)
        2'd0:    begin wstrb = 4'b0001; wdata = {24'h0, rt[31:24]}; end
        2'd1:    begin wstrb = 4'b0011; wdata = {16'h0, rt[31:16]}; end
        2'd2:    begin wstrb = 4'b0111; wdata = {8'h0, rt[31:8]};   end
        default: begin wstrb = 4'b1111; wdata = rt;                 end
      endcase
    end else if (mem_op[MEM_OP_SWR]) begin
      bus_addr = word_addr;
      case (off)
        2'd0:    begin wstrb = 4'b1111; wdata = rt;                 end
        2'd1:    begin wstrb = 4'b1110; wdata = {rt[23:0], 8'h0};   end
        2'd2:    begin wstrb = 4'b1100; wdata = {rt[15:0], 16'h0};  end
        default: begin wstrb = 4'b1000; wdata = {rt[7:0], 24'h0};   end
      endcase
    end
  end

endmodule

// File: rtl/mem_req_unit.sv
// Data-side memory request unit: accepts one EX-stage load/store, runs a single
// SRAM-like bus transaction and returns the raw word plus byte offset to MEM/WB.
module mem_req_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                es_req_valid,
  output logic                es_req_ready,
  input  logic [MEM_OP_W-1:0] es_mem_op,
  input  logic [ADDR_W-1:0]   es_addr,
  input  logic [DATA_W-1:0]   es_rt_value,
  input  logic                flush,
  output logic                data_req,
  output logic                data_wr,
  output logic [1:0]          data_size,
  output logic [ADDR_W-1:0]   data_addr,
  output logic [3:0]          data_wstrb,
  output logic [DATA_W-1:0]   data_wdata,
  input  logic                data_addr_ok,
  input  logic                data_data_ok,
  input  logic [DATA_W-1:0]   data_rdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic [1:0]          resp_rdata_type,
  output logic                resp_ex,
  output logic                resp_is_store
);

  state_t            state;
  logic              cancel;
  logic              accept;
  logic [1:0]        f_size;
  logic [ADDR_W-1:0] f_addr;
  logic [3:0]        f_wstrb;
  logic [31:0]       f_wdata;
  logic              f_misaligned;
  logic              f_is_store;

  store_formatter #(.ADDR_W(ADDR_W)) u_fmt (
    .mem_op     (es_mem_op),
    .addr       (es_addr),
    .rt         (es_rt_value),
    .size       (f_size),
    .bus_addr   (f_addr),
    .wstrb      (f_wstrb),
    .wdata      (f_wdata),
    .misaligned (f_misaligned),
    .is_store   (f_is_store)
  );

  assign es_req_ready = (state == S_IDLE) && !cancel;
  assign accept       = es_req_valid && es_req_ready && !flush;

  // NOTE: all state is updated with non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      cancel          <= 1'b0;
      data_req        <= 1'b0;
      data_wr         <= 1'b0;
      data_size       <= 2'd0;
      data_addr       <= '0;
      data_wstrb      <= 4'b0000;
      data_wdata      <= '0;
      resp_valid      <= 1'b0;
      resp_rdata      <= '0;
      resp_rdata_type <= 2'd0;
      resp_ex         <= 1'b0;
      resp_is_store   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            data_wr         <= f_is_store;
            data_size       <= f_size;
            data_addr       <= f_addr;
            data_wstrb      <= f_wstrb;
            data_wdata      <= f_wdata;
            resp_rdata      <= '0;
            resp_rdata_type <= es_addr[1:0];
            resp_ex         <= f_misaligned;
            resp_is_store   <= f_is_store;
            // an address error never reaches the bus
            if (f_misaligned) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
            end else begin
              state    <= S_REQ;
              data_req <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (flush) cancel <= 1'b1;
          if (data_addr_ok) begin
            data_req <= 1'b0;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (data_data_ok) begin
            cancel <= 1'b0;
            if (flush || cancel) begin
              state <= S_IDLE;
            end else begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              if (!data_wr) resp_rdata <= data_rdata;
            end
          end else if (flush) begin
            cancel <= 1'b1;
          end
        end
        S_RESP: begin
          if (flush || resp_ready) begin
            resp_valid <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_unit.sv
// Directed bench for mem_req_unit: expected responses are queued at issue time
// and popped when resp_valid is seen; bus fields are compared at each step.
module tb_mem_req_unit;
  import mem_pkg::*;

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  rtype;
    logic        ex;
    logic        st;
  } resp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        es_req_valid;
  logic        es_req_ready;
  logic [11:0] es_mem_op;
  logic [31:0] es_addr;
  logic [31:0] es_rt_value;
  logic        flush;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_rdata_type;
  logic        resp_ex;
  logic        resp_is_store;

  int    pass_cnt  = 0;
  int    total_cnt = 0;
  resp_t sb_q[$];

  always #5 clk = ~clk;

  mem_req_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .es_req_valid    (es_req_valid),
    .es_req_ready    (es_req_ready),
    .es_mem_op       (es_mem_op),
    .es_addr         (es_addr),
    .es_rt_value     (es_rt_value),
    .flush           (flush),
    .data_req        (data_req),
    .data_wr         (data_wr),
    .data_size       (data_size),
    .data_addr       (data_addr),
    .data_wstrb      (data_wstrb),
    .data_wdata      (data_wdata),
    .data_addr_ok    (data_addr_ok),
    .data_data_ok    (data_data_ok),
    .data_rdata      (data_rdata),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_rdata      (resp_rdata),
    .resp_rdata_type (resp_rdata_type),
    .resp_ex         (resp_ex),
    .resp_is_store   (resp_is_store)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] op(input int idx);
    logic [11:0] v;
    v = 12'd1 << idx;
    return v;
  endfunction

  function automatic resp_t mk(input logic [31:0] rd, input logic [1:0] ty,
                               input logic ex, input logic st);
    resp_t r;
    r.rdata = rd;
    r.rtype = ty;
    r.ex    = ex;
    r.st    = st;
    return r;
  endfunction

  task automatic issue(input logic [11:0] o, input logic [31:0] a, input logic [31:0] rt,
                       input logic push, input resp_t exp);
    check("accept_ready", 32'(es_req_ready), 1);
    es_req_valid = 1'b1;
    es_mem_op    = o;
    es_addr      = a;
    es_rt_value  = rt;
    if (push) sb_q.push_back(exp);
    tick();
    es_req_valid = 1'b0;
  endtask

  task automatic check_bus(input string tag, input logic [31:0] a, input logic [1:0] sz,
                           input logic [3:0] st, input logic [31:0] wd, input logic wr);
    check({tag, "_req"},   32'(data_req), 1);
    check({tag, "_addr"},  data_addr, a);
    check({tag, "_size"},  32'(data_size), 32'(sz));
    check({tag, "_wstrb"}, 32'(data_wstrb), 32'(st));
    check({tag, "_wdata"}, data_wdata, wd);
    check({tag, "_wr"},    32'(data_wr), 32'(wr));
  endtask

  // Slave model: addr_ok after addr_wait cycles in REQ, data_ok data_wait cycles later.
  task automatic serve(input int addr_wait, input int data_wait, input logic [31:0] rd);
    repeat (addr_wait) tick();
    check("req_hold", 32'(data_req), 1);
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    check("req_drop", 32'(data_req), 0);
    repeat (data_wait) tick();
    data_data_ok = 1'b1;
    data_rdata   = rd;
    tick();
    data_data_ok = 1'b0;
    data_rdata   = 32'hDEAD_BEEF;
  endtask

  task automatic wait_resp(input string tag, input int max_cycles);
    int n = 0;
    while (!resp_valid && n < max_cycles) begin
      tick();
      n++;
    end
    check({tag, "_resp_timeout"}, 32'(resp_valid), 1);
  endtask

  task automatic pop_check(input string tag);
    resp_t e;
    check({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({tag, "_rdata"},    resp_rdata, e.rdata);
      check({tag, "_type"},     32'(resp_rdata_type), 32'(e.rtype));
      check({tag, "_ex"},       32'(resp_ex), 32'(e.ex));
      check({tag, "_is_store"}, 32'(resp_is_store), 32'(e.st));
    end
  endtask

  task automatic handshake(input string tag);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(resp_valid), 0);
  endtask

  initial begin
    reset        = 1'b1;
    es_req_valid = 1'b0;
    es_mem_op    = '0;
    es_addr      = '0;
    es_rt_value  = '0;
    flush        = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = 32'hDEAD_BEEF;
    resp_ready   = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_ready", 32'(es_req_ready), 1);
    check("rst_req", 32'(data_req), 0);
    check("rst_valid", 32'(resp_valid), 0);
    check("rst_addr", data_addr, 0);
    check("rst_wstrb", 32'(data_wstrb), 0);
    check("rst_rdata", resp_rdata, 0);
    reset = 1'b0;
    tick();

    // sb with immediate slave: req one cycle after accept, resp_valid at cycle 3
    issue(op(MEM_OP_SB), 32'h8000_0003, 32'h1122_3344, 1'b1, mk(32'h0, 2'd3, 1'b0, 1'b1));
    check_bus("sb", 32'h8000_0003, 2'd0, 4'b1000, 32'h4444_4444, 1'b1);
    check("sb_busy", 32'(es_req_ready), 0);
    serve(0, 0, 32'h0);
    check("sb_latency", 32'(resp_valid), 1);
    pop_check("sb");
    handshake("sb");

    // swr / swl at offset 1
    issue(op(MEM_OP_SWR), 32'h0000_1001, 32'hAABB_CCDD, 1'b1, mk(32'h0, 2'd1, 1'b0, 1'b1));
    check_bus("swr", 32'h0000_1000, 2'd2, 4'b1110, 32'hBBCC_DD00, 1'b1);
    serve(1, 0, 32'h0);
    wait_resp("swr", 10);
    pop_check("swr");
    handshake("swr");

    issue(op(MEM_OP_SWL), 32'h0000_1001, 32'hAABB_CCDD, 1'b1, mk(32'h0, 2'd1, 1'b0, 1'b1));
    check_bus("swl", 32'h0000_1000, 2'd2, 4'b0011, 32'h0000_AABB, 1'b1);
    serve(0, 0, 32'h0);
    wait_resp("swl", 10);
    pop_check("swl");
    handshake("swl");

    // lh with slow data_ok, response held under backpressure
    issue(op(MEM_OP_LH), 32'h0000_2002, 32'h0, 1'b1, mk(32'h8765_4321, 2'd2, 1'b0, 1'b0));
    check_bus("lh", 32'h0000_2002, 2'd1, 4'b0000, 32'h0, 1'b0);
    serve(0, 5, 32'h8765_4321);
    check("lh_valid", 32'(resp_valid), 1);
    pop_check("lh");
    for (int i = 0; i < 2; i++) begin
      tick();
      check("lh_hold_valid", 32'(resp_valid), 1);
      check("lh_hold_rdata", resp_rdata, 32'h8765_4321);
      check("lh_hold_type", 32'(resp_rdata_type), 2);
    end
    handshake("lh");

    // Misaligned lw / sh: no bus request, response at cycle 1
    issue(op(MEM_OP_LW), 32'h0000_3001, 32'h0, 1'b1, mk(32'h0, 2'd1, 1'b1, 1'b0));
    check("lw_mis_noreq", 32'(data_req), 0);
    check("lw_mis_valid", 32'(resp_valid), 1);
    pop_check("lw_mis");
    handshake("lw_mis");
    check("lw_mis_noreq2", 32'(data_req), 0);

    issue(op(MEM_OP_SH), 32'h0000_3001, 32'h1234_5678, 1'b1, mk(32'h0, 2'd1, 1'b1, 1'b1));
    check("sh_mis_noreq", 32'(data_req), 0);
    check("sh_mis_valid", 32'(resp_valid), 1);
    pop_check("sh_mis");
    handshake("sh_mis");

    // Flush during WAIT: transaction completes, no response
    issue(op(MEM_OP_LW), 32'h0000_4000, 32'h0, 1'b0, mk(32'h0, 2'd0, 1'b0, 1'b0));
    check("fl_req", 32'(data_req), 1);
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_ready_c1", 32'(es_req_ready), 0);
    tick();
    data_data_ok = 1'b1;
    data_rdata   = 32'h5555_AAAA;
    check("fl_ready_c2", 32'(es_req_ready), 0);
    tick();
    data_data_ok = 1'b0;
    data_rdata   = 32'hDEAD_BEEF;
    check("fl_ready_after", 32'(es_req_ready), 1);
    check("fl_no_valid", 32'(resp_valid), 0);
    tick();
    check("fl_no_valid2", 32'(resp_valid), 0);
    check("fl_no_req", 32'(data_req), 0);

    // valid and flush together in IDLE: suppressed
    es_req_valid = 1'b1;
    es_mem_op    = op(MEM_OP_LW);
    es_addr      = 32'h0000_6000;
    flush        = 1'b1;
    tick();
    es_req_valid = 1'b0;
    flush        = 1'b0;
    check("idle_flush_noreq", 32'(data_req), 0);
    check("idle_flush_ready", 32'(es_req_ready), 1);
    tick();
    check("idle_flush_noreq2", 32'(data_req), 0);

    // Back-to-back lw: second accepted the cycle after the first handshake
    issue(op(MEM_OP_LW), 32'h0000_5000, 32'h0, 1'b1, mk(32'hCAFE_F00D, 2'd0, 1'b0, 1'b0));
    check_bus("b2b1", 32'h0000_5000, 2'd2, 4'b0000, 32'h0, 1'b0);
    serve(0, 0, 32'hCAFE_F00D);
    wait_resp("b2b1", 10);
    pop_check("b2b1");
    resp_ready   = 1'b1;
    es_req_valid = 1'b1;
    es_mem_op    = op(MEM_OP_LW);
    es_addr      = 32'h0000_5004;
    sb_q.push_back(mk(32'h0BAD_CAFE, 2'd0, 1'b0, 1'b0));
    check("b2b_hs_notready", 32'(es_req_ready), 0);
    tick();
    resp_ready = 1'b0;
    check("b2b_ready", 32'(es_req_ready), 1);
    check("b2b_valid_drop", 32'(resp_valid), 0);
    tick();
    es_req_valid = 1'b0;
    check_bus("b2b2", 32'h0000_5004, 2'd2, 4'b0000, 32'h0, 1'b0);
    serve(0, 1, 32'h0BAD_CAFE);
    wait_resp("b2b2", 10);
    pop_check("b2b2");
    handshake("b2b2");

    // Reset mid-transaction returns to IDLE
    issue(op(MEM_OP_LBU), 32'h0000_7003, 32'h0, 1'b0, mk(32'h0, 2'd0, 1'b0, 1'b0));
    check_bus("lbu", 32'h0000_7003, 2'd0, 4'b0000, 32'h0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_req", 32'(data_req), 0);
    check("midrst_ready", 32'(es_req_ready), 1);
    check("midrst_addr", data_addr, 0);

    check("sb_drained", 32'(sb_q.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
